// File: rtl/dff_mem_pkg.sv
// ============================================================================
// Module      : dff_mem_pkg
// Description : Shared state encoding and width helpers for the scratchpad.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dff_mem_pkg;

    typedef enum logic [1:0] {
        SP_IDLE  = 2'd0,
        SP_READ  = 2'd1,
        SP_CLEAR = 2'd2
    } sp_state_t;

    localparam int C_BYTE_W = 8;

    // Address width for a given depth; a depth of 1 still needs one bit.
    function automatic int sp_addr_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic int sp_be_w(input int data_w);
        return data_w / C_BYTE_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dff_mem_array.sv
// ============================================================================
// Module      : dff_mem_array
// Description : Flip-flop storage, byte-enable write port, async read port.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dff_mem_array
    import dff_mem_pkg::*;
#(
    parameter  int D_W  = 8,
    parameter  int WORD = 8,
    localparam int AW   = sp_addr_w(WORD),
    localparam int BE_W = sp_be_w(D_W)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [BE_W-1:0] wbe,
    input  logic [D_W-1:0]  wdata,
    input  logic [AW-1:0]   raddr,
    output logic [D_W-1:0]  rdata
);

    logic [D_W-1:0] r_mem [WORD];

    // Contents are deliberately left unreset; the clear sequencer handles that.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe[i]) begin
                    r_mem[waddr][i*C_BYTE_W +: C_BYTE_W] <= wdata[i*C_BYTE_W +: C_BYTE_W];
                end
            end
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/dff_scratchpad.sv
// ============================================================================
// Module      : dff_scratchpad
// Description : Byte-lane scratchpad with handshaked wrapping burst reads
//               and a hardware clear sweep.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dff_scratchpad
    import dff_mem_pkg::*;
#(
    parameter  int D_W     = 8,
    parameter  int WORD    = 8,
    parameter  bit RST_CLR = 1'b0,
    localparam int AW      = sp_addr_w(WORD),
    localparam int BE_W    = sp_be_w(D_W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [BE_W-1:0] wr_be,
    input  logic [D_W-1:0]  wr_data,
    input  logic            rd_start,
    input  logic [AW-1:0]   rd_addr,
    input  logic [AW:0]     rd_len,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [D_W-1:0]  rd_data,
    output logic            rd_last,
    input  logic            clr_req,
    output logic            busy
);

    localparam logic [AW-1:0] c_ptr_one   = AW'(1);
    localparam logic [AW-1:0] c_last_addr = AW'(WORD - 1);
    localparam logic [AW:0]   c_cnt_one   = (AW+1)'(1);
    localparam logic [AW:0]   c_cnt_two   = (AW+1)'(2);

    sp_state_t        r_state;
    logic [AW-1:0]    r_ptr;
    logic [AW:0]      r_cnt;
    logic [AW-1:0]    r_clr_addr;
    logic             r_valid;
    logic             r_last;
    logic [D_W-1:0]   r_data;
    logic             r_busy;

    logic             w_mem_we;
    logic [AW-1:0]    w_mem_waddr;
    logic [BE_W-1:0]  w_mem_be;
    logic [D_W-1:0]   w_mem_wdata;
    logic [AW-1:0]    w_ptr_next;
    logic [AW-1:0]    w_fetch_addr;
    logic [D_W-1:0]   w_fetch_word;

    // The clear sweep owns the write port; host writes are dropped meanwhile.
    always_comb begin
        w_mem_we    = wr_en;
        w_mem_waddr = wr_addr;
        w_mem_be    = wr_be;
        w_mem_wdata = wr_data;
        if (r_state == SP_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clr_addr;
            w_mem_be    = '1;
            w_mem_wdata = '0;
        end
    end

    // Power-of-two depth, so the natural overflow gives the address wrap.
    assign w_ptr_next   = r_ptr + c_ptr_one;
    assign w_fetch_addr = r_valid ? w_ptr_next : r_ptr;

    dff_mem_array #(
        .D_W  (D_W),
        .WORD (WORD)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (w_mem_waddr),
        .wbe   (w_mem_be),
        .wdata (w_mem_wdata),
        .raddr (w_fetch_addr),
        .rdata (w_fetch_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RST_CLR ? SP_CLEAR : SP_IDLE;
            r_busy     <= RST_CLR;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_clr_addr <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
        end else begin
            case (r_state)
                SP_IDLE: begin
                    if (rd_start && (rd_len != '0)) begin
                        r_state <= SP_READ;
                        r_ptr   <= rd_addr;
                        r_cnt   <= rd_len;
                        r_busy  <= 1'b1;
                    end else if (clr_req) begin
                        r_state    <= SP_CLEAR;
                        r_clr_addr <= '0;
                        r_busy     <= 1'b1;
                    end
                end

                SP_READ: begin
                    if (!r_valid) begin
                        // First fetch cycle after acceptance.
                        r_valid <= 1'b1;
                        r_data  <= w_fetch_word;
                        r_last  <= (r_cnt == c_cnt_one);
                    end else if (rd_ready) begin
                        r_ptr <= w_ptr_next;
                        r_cnt <= r_cnt - c_cnt_one;
                        if (r_cnt == c_cnt_one) begin
                            r_state <= SP_IDLE;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_data  <= '0;
                        end else begin
                            r_data <= w_fetch_word;
                            r_last <= (r_cnt == c_cnt_two);
                        end
                    end
                end

                SP_CLEAR: begin
                    if (r_clr_addr == c_last_addr) begin
                        r_state    <= SP_IDLE;
                        r_busy     <= 1'b0;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + c_ptr_one;
                    end
                end

                default: begin
                    r_state <= SP_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_data  <= '0;
                end
            endcase
        end
    end

    assign rd_valid = r_valid;
    assign rd_data  = r_data;
    assign rd_last  = r_last;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_dff_scratchpad.sv
// ============================================================================
// Module      : tb_dff_scratchpad
// Description : Self-checking bench: byte-lane table, burst/wrap/stall/clear
//               sequences and random traffic against an array model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dff_scratchpad;

    logic        clk = 1'b0;
    logic        rst, rst1;
    always #5 clk = ~clk;

    // Main instance: 16-bit words, 8 deep, no clear on reset.
    logic        wr_en, rd_start, rd_ready, clr_req;
    logic [2:0]  wr_addr, rd_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;
    logic [3:0]  rd_len;
    logic        rd_valid, rd_last, busy;
    logic [15:0] rd_data;

    dff_scratchpad #(.D_W(16), .WORD(8), .RST_CLR(1'b0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .clr_req(clr_req), .busy(busy)
    );

    // Second instance: 8-bit, 4 deep, clear sweep after reset.
    logic        valid1, last1, busy1;
    logic [7:0]  data1;

    dff_scratchpad #(.D_W(8), .WORD(4), .RST_CLR(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .wr_en(1'b0), .wr_addr(2'd0), .wr_be(1'b0),
        .wr_data(8'd0), .rd_start(1'b0), .rd_addr(2'd0), .rd_len(3'd0),
        .rd_ready(1'b0), .rd_valid(valid1), .rd_data(data1), .rd_last(last1),
        .clr_req(1'b0), .busy(busy1)
    );

    int n_checks = 0;
    int n_err    = 0;
    logic [15:0] model_mem [8];

    typedef struct {
        logic [2:0]  addr;
        logic [1:0]  be;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [1:0] be, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        step();
        wr_en = 1'b0;
        for (int i = 0; i < 2; i++)
            if (be[i]) model_mem[a][i*8 +: 8] = d[i*8 +: 8];
    endtask

    // Runs one burst; each presented beat is compared against the model word at
    // the expected (wrapping) address. cycles counts from first valid to done.
    task automatic do_burst(input logic [2:0] a, input int len, input int stall_pct,
                            output int cycles, output logic [15:0] first);
        int         beats;
        logic [2:0] ea;
        logic       rdy;
        rd_start = 1'b1; rd_addr = a; rd_len = 4'(len); rd_ready = 1'b0;
        step();
        rd_start = 1'b0;
        chk("busy_rise", 16'(busy), 16'd1);
        chk("fetch_gap", 16'(rd_valid), 16'd0);
        step();
        beats = 0; ea = a; cycles = 0; first = '0;
        while (beats < len && cycles < 200) begin
            rdy = ($urandom_range(0, 99) >= stall_pct);
            chk("beat_valid", 16'(rd_valid), 16'd1);
            if (rd_valid) begin
                chk("beat_data", rd_data, model_mem[ea]);
                chk("beat_last", 16'(rd_last), 16'(beats == len - 1));
                if (rdy) begin
                    if (beats == 0) first = rd_data;
                    beats++;
                    ea++;
                end
            end
            rd_ready = rdy;
            step();
            cycles++;
        end
        rd_ready = 1'b0;
        if (beats < len) begin
            n_checks++; n_err++;
            $display("FAIL burst_timeout: got %0d beats expected %0d", beats, len);
        end
        chk("valid_drop", 16'(rd_valid), 16'd0);
        chk("data_zero", rd_data, 16'd0);
        chk("busy_fall", 16'(busy), 16'd0);
    endtask

    task automatic count_busy(input logic which, output int n);
        n = 0;
        while (((which == 1'b0) ? busy : busy1) && n < 50) begin
            n++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, n;
        logic [15:0] first;

        vecs[0] = '{3'd3, 2'b11, 16'h1234, 16'h1234};
        vecs[1] = '{3'd3, 2'b10, 16'hFF00, 16'hFF34};
        vecs[2] = '{3'd3, 2'b00, 16'hAAAA, 16'hFF34};
        vecs[3] = '{3'd3, 2'b01, 16'hBBCD, 16'hFFCD};
        vecs[4] = '{3'd5, 2'b01, 16'h9977, 16'h0077};
        vecs[5] = '{3'd5, 2'b10, 16'h8800, 16'h8877};
        vecs[6] = '{3'd0, 2'b11, 16'hDEAD, 16'hDEAD};
        vecs[7] = '{3'd0, 2'b00, 16'h0000, 16'hDEAD};

        wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
        rd_start = 0; rd_addr = 0; rd_len = 0; rd_ready = 0; clr_req = 0;
        rst = 1'b1; rst1 = 1'b1;
        @(negedge clk);
        step();
        chk("rst_valid", 16'(rd_valid), 16'd0);
        chk("rst_last", 16'(rd_last), 16'd0);
        chk("rst_data", rd_data, 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst1_busy", 16'(busy1), 16'd1);
        chk("rst1_valid", {8'd0, data1} | 16'(valid1) | 16'(last1), 16'd0);
        rst = 1'b0; rst1 = 1'b0;

        // Clear-on-reset instance: WORD cycles busy, and a mid-clear reset restarts.
        count_busy(1'b1, n);
        chk("rstclr_len", 16'(n), 16'd4);
        rst1 = 1'b1; step(); rst1 = 1'b0;
        step(); step();
        rst1 = 1'b1; step(); rst1 = 1'b0;
        count_busy(1'b1, n);
        chk("rstclr_restart", 16'(n), 16'd4);

        // Known memory contents before any read.
        clr_req = 1'b1; step(); clr_req = 1'b0;
        count_busy(1'b0, n);
        chk("init_clr_len", 16'(n), 16'd8);
        for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;

        // Byte-lane table.
        for (int v = 0; v < 8; v++) begin
            do_write(vecs[v].addr, vecs[v].be, vecs[v].data);
            do_burst(vecs[v].addr, 1, 0, cyc, first);
            chk($sformatf("lane_vec%0d", v), first, vecs[v].exp);
        end

        // Full-depth burst of a uniform pattern at full rate.
        for (int i = 0; i < 8; i++) do_write(3'(i), 2'b11, 16'hA5A5);
        do_burst(3'd0, 8, 0, cyc, first);
        chk("full_rate_cycles", 16'(cyc), 16'd8);
        chk("full_first", first, 16'hA5A5);

        // Wrapping burst over distinct words.
        for (int i = 0; i < 8; i++) do_write(3'(i), 2'b11, 16'(16'h0F00 + i * 16'h0111));
        do_burst(3'd6, 4, 0, cyc, first);
        chk("wrap_first", first, 16'h1566);
        chk("wrap_cycles", 16'(cyc), 16'd4);

        // Stalled burst.
        do_burst(3'd2, 6, 50, cyc, first);

        // Zero length is a no-op.
        rd_start = 1'b1; rd_addr = 3'd1; rd_len = 4'd0; step(); rd_start = 1'b0;
        chk("len0_busy", 16'(busy), 16'd0);
        step();
        chk("len0_valid", 16'(rd_valid), 16'd0);

        // Same-cycle write and fetch: old value is returned, new value later.
        do_write(3'd0, 2'b11, 16'h0A0A);
        do_write(3'd1, 2'b11, 16'h1B1B);
        rd_start = 1'b1; rd_addr = 3'd0; rd_len = 4'd2; step(); rd_start = 1'b0;
        step();
        chk("coll_b0", rd_data, 16'h0A0A);
        rd_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd1; wr_be = 2'b11; wr_data = 16'h2C2C;
        step();
        wr_en = 1'b0; model_mem[1] = 16'h2C2C;
        chk("coll_old", rd_data, 16'h1B1B);
        chk("coll_last", 16'(rd_last), 16'd1);
        step();
        rd_ready = 1'b0;
        chk("coll_done", 16'(busy), 16'd0);
        do_burst(3'd1, 1, 0, cyc, first);
        chk("coll_new", first, 16'h2C2C);

        // Reset during beat 2 of an 8-beat burst.
        rd_start = 1'b1; rd_addr = 3'd0; rd_len = 4'd8; rd_ready = 1'b1; step();
        rd_start = 1'b0;
        step(); step();
        chk("rstb_beat2", rd_data, model_mem[1]);
        rst = 1'b1; step(); rst = 1'b0; rd_ready = 1'b0;
        chk("rstb_valid", 16'(rd_valid), 16'd0);
        chk("rstb_data", rd_data, 16'd0);
        chk("rstb_busy", 16'(busy), 16'd0);
        step();
        chk("rstb_quiet", 16'(rd_valid), 16'd0);

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0)
                do_burst(3'($urandom_range(0, 7)), $urandom_range(1, 8), 30, cyc, first);
            else
                do_write(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 16'($urandom));
        end

        // Clear with host writes active throughout.
        for (int i = 0; i < 8; i++) do_write(3'(i), 2'b11, 16'hFFFF);
        wr_en = 1'b1; wr_be = 2'b11; wr_data = 16'hFFFF; wr_addr = 3'd4;
        clr_req = 1'b1; step(); clr_req = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            wr_addr = 3'($urandom_range(0, 7));
            n++;
            step();
        end
        wr_en = 1'b0;
        chk("clr_len", 16'(n), 16'd8);
        for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
        do_burst(3'd0, 8, 0, cyc, first);
        chk("clr_first", first, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dff_scratchpad.md
# dff_scratchpad

Parametrised flip-flop scratchpad, the successor to the single-port DFF memory used for small operand and weight buffers in the TPU datapath. It adds byte-lane write enables, registered burst reads with a valid/ready handshake and address wrap, and a hardware clear sequencer. It sits between the host load path, which writes, and the systolic array feeder, which streams reads.

## Interface
- `D_W`, default 8: word width in bits; must be a multiple of 8.
- `WORD`, default 8: depth in words; power of two, ≥ 2.
- `RST_CLR`, default 0: when 1, a clear sweep starts automatically after reset.
- `AW`, derived: `$clog2(WORD)`. `BE_W`, derived: `D_W/8`.

Ports (clock and reset first):
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  AW  write address.
- `wr_be`  in  BE_W  byte-lane enables; bit i gates `wr_data[8i+7:8i]`.
- `wr_data`  in  D_W  write data.
- `rd_start`  in  1  starts a burst; sampled only in IDLE.
- `rd_addr`  in  AW  burst start address.
- `rd_len`  in  AW+1  burst length in words, 1..WORD; 0 means no-op.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_data`  out  D_W  read word; forced to 0 whenever `rd_valid` is 0.
- `rd_last`  out  1  current beat is the final beat of the burst.
- `clr_req`  in  1  requests a clear sweep; sampled only in IDLE.
- `busy`  out  1  high in READ or CLEAR.

## Operation
- FSM states: IDLE, READ, CLEAR.
  - IDLE → READ on `rd_start` with `rd_len` ≠ 0.
  - IDLE → CLEAR on `clr_req`.
  - `rd_start` has priority over `clr_req` when both are high.
  - READ → IDLE on the handshake of the last beat.
  - CLEAR → IDLE after word WORD-1 is cleared.
- `rd_start` and `clr_req` are ignored outside IDLE. There is no queueing.
- Writes:
  - Accepted in IDLE and READ; dropped in CLEAR.
  - Only enabled byte lanes change. `wr_be` = 0 is a no-op.
- Reads:
  - A read pointer loads `rd_addr`. A beat counter loads `rd_len`.
  - On each beat where `rd_valid` && `rd_ready`: pointer increments modulo WORD (WORD-1 wraps to 0), counter decrements, and the next word is fetched into `rd_data`.
  - While `rd_valid` && !`rd_ready`: `rd_data`, `rd_last` and the pointer hold stable.
- Collision: a same-cycle write and fetch of the same address is read-first; the fetched word is the old value. A write takes effect for any fetch on a later cycle.
- Clear:
  - Writes 0 to addresses 0..WORD-1, one per cycle, in ascending order.
  - A concurrent `wr_en` is dropped.
- Reset:
  - State goes to IDLE, or CLEAR if `RST_CLR` = 1.
  - `rd_valid`, `rd_last` and `rd_data` reset to 0. `busy` resets to `RST_CLR`.
  - Counters reset to 0. Memory contents are not reset.
  - Reset mid-burst aborts the burst with no further beats. Reset mid-clear aborts the clear, or restarts it at address 0 if `RST_CLR` = 1.

## Timing
- `rd_start` accepted at edge t: `rd_valid` = 1 after edge t+1, with `mem[rd_addr]`.
- With `rd_ready` held high, one beat per cycle. An N-beat burst completes in N cycles after the first valid.
- `rd_last` = 1 together with the beat when the counter is 1.
- `busy` rises the cycle after acceptance. It falls the cycle after the final handshake (READ) or after the cycle clearing word WORD-1 (CLEAR).
- CLEAR occupancy: exactly WORD cycles.
- Back-to-back bursts need at least one IDLE cycle between them.

## Structure
- Package `dff_mem_pkg`:
  - state enum `sp_state_t` (IDLE/READ/CLEAR);
  - width helper constants for AW and BE_W.
- Sub-module `dff_mem_array`: storage with a byte-enable write port and an asynchronous read port. The controller in `dff_scratchpad` owns the FSM, counters and output register.

## Test plan
- Write 0xA5 to 0..7 with `wr_be`=1, then burst `rd_addr`=0, `rd_len`=8, `rd_ready`=1 → 8 beats of 0xA5, `rd_last` on beat 8, `busy` falls one cycle later.
- With `D_W`=16: write 0x1234 to address 3, then `wr_be`=2'b10 with 0xFF00 → reading address 3 returns 0xFF34.
- Burst `rd_addr`=6, `rd_len`=4 → address order 6, 7, 0, 1 (wrap).
- Toggle `rd_ready` 1,0,0,1 mid-burst → `rd_data` is stable during stalls, no beat is lost or duplicated, and `rd_data` = 0 when `rd_valid` = 0.
- Fill memory with 0xFF, assert `clr_req` with `wr_en` active throughout → `busy` high for exactly WORD cycles; afterwards every address reads 0.
- Assert `rst` at beat 2 of an 8-beat burst → `rd_valid` = 0 the next cycle; state IDLE, or CLEAR if `RST_CLR` = 1.
